// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse cursor tracker: FSM states,
// byte1 bit positions and default screen resolution.
package mouse_pkg;

  typedef enum logic [2:0] {
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    WAIT_B4,
    UPDATE
  } state_t;

  localparam int B1_LEFT   = 0;
  localparam int B1_RIGHT  = 1;
  localparam int B1_MIDDLE = 2;
  localparam int B1_SYNC   = 3;
  localparam int B1_XSIGN  = 4;
  localparam int B1_YSIGN  = 5;
  localparam int B1_XOVF   = 6;
  localparam int B1_YOVF   = 7;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

endpackage

// File: rtl/mouse_axis_update.sv
// One cursor axis: sign-extend and scale a 9-bit PS/2 delta, add or
// subtract it from the current position and clamp to the screen range.
module mouse_axis_update #(
  parameter int RES         = 640,
  parameter int POS_W       = 10,
  parameter int SPEED_SHIFT = 0
) (
  input  logic [POS_W-1:0]  pos,
  input  logic signed [8:0] delta,
  input  logic              negate,
  output logic [POS_W-1:0]  pos_next
);

  localparam int EW = POS_W + 4;
  localparam logic signed [EW-1:0] MAX_POS = EW'(RES - 1);

  logic signed [EW-1:0] delta_ext;
  logic signed [EW-1:0] step;
  logic signed [EW-1:0] base;
  logic signed [EW-1:0] sum;

  assign delta_ext = {{(EW-9){delta[8]}}, delta};
  assign step      = delta_ext <<< SPEED_SHIFT;
  assign base      = signed'({4'b0000, pos});
  assign sum       = negate ? (base - step) : (base + step);

  // The wide sum can never wrap, so its sign bit alone tells underflow.
  always_comb begin
    pos_next = sum[POS_W-1:0];
    if (sum[EW-1]) begin
      pos_next = '0;
    end else if (sum > MAX_POS) begin
      pos_next = POS_W'(RES - 1);
    end
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse packet parser that keeps a clamped on-screen cursor position,
// button state and optional wheel delta.
module mouse_cursor_tracker
  import mouse_pkg::*;
#(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int POS_W       = 10,
  parameter int WHEEL_EN    = 0,
  parameter int SPEED_SHIFT = 0,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic [2:0]       buttons,
  output logic [3:0]       wheel,
  output logic             pkt_valid,
  output logic             sync_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      hdr_btn;
  logic            hdr_xsign, hdr_ysign, hdr_xovf, hdr_yovf;
  logic [7:0]      x_byte, y_byte;
  logic [3:0]      wheel_nib;
  logic signed [8:0] dx, dy;
  logic [POS_W-1:0]  x_next, y_next;
  logic            timed_out;
  logic            b1_slot;

  assign dx = hdr_xovf ? 9'd0 : {hdr_xsign, x_byte};
  assign dy = hdr_yovf ? 9'd0 : {hdr_ysign, y_byte};

  assign timed_out = ((state == WAIT_B2) || (state == WAIT_B3) || (state == WAIT_B4))
                     && (timer == TW'(TIMEOUT_CYC));

  // Cycles in which an incoming byte is judged as a possible first byte.
  assign b1_slot = (state == WAIT_B1) || (state == UPDATE) || timed_out;

  mouse_axis_update #(.RES(H_RES), .POS_W(POS_W), .SPEED_SHIFT(SPEED_SHIFT)) u_x (
    .pos      (x_pos),
    .delta    (dx),
    .negate   (1'b0),
    .pos_next (x_next)
  );

  // PS/2 positive Y is upward while screen Y grows downward.
  mouse_axis_update #(.RES(V_RES), .POS_W(POS_W), .SPEED_SHIFT(SPEED_SHIFT)) u_y (
    .pos      (y_pos),
    .delta    (dy),
    .negate   (1'b1),
    .pos_next (y_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_B1;
      timer     <= '0;
      hdr_btn   <= '0;
      hdr_xsign <= 1'b0;
      hdr_ysign <= 1'b0;
      hdr_xovf  <= 1'b0;
      hdr_yovf  <= 1'b0;
      x_byte    <= '0;
      y_byte    <= '0;
      wheel_nib <= '0;
      x_pos     <= POS_W'(H_RES / 2);
      y_pos     <= POS_W'(V_RES / 2);
      buttons   <= '0;
      wheel     <= '0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (b1_slot) begin
        timer <= '0;
        if (state == UPDATE) begin
          x_pos     <= x_next;
          y_pos     <= y_next;
          buttons   <= hdr_btn;
          wheel     <= (WHEEL_EN != 0) ? wheel_nib : 4'd0;
          pkt_valid <= 1'b1;
        end
        if (rx_valid && rx_data[B1_SYNC]) begin
          hdr_btn   <= {rx_data[B1_MIDDLE], rx_data[B1_RIGHT], rx_data[B1_LEFT]};
          hdr_xsign <= rx_data[B1_XSIGN];
          hdr_ysign <= rx_data[B1_YSIGN];
          hdr_xovf  <= rx_data[B1_XOVF];
          hdr_yovf  <= rx_data[B1_YOVF];
          state     <= WAIT_B2;
        end else begin
          state <= WAIT_B1;
        end
        sync_err <= timed_out || (rx_valid && !rx_data[B1_SYNC]);
      end else if (rx_valid) begin
        timer <= '0;
        case (state)
          WAIT_B2: begin
            x_byte <= rx_data;
            state  <= WAIT_B3;
          end
          WAIT_B3: begin
            y_byte <= rx_data;
            state  <= (WHEEL_EN != 0) ? WAIT_B4 : UPDATE;
          end
          WAIT_B4: begin
            wheel_nib <= rx_data[3:0];
            state     <= UPDATE;
          end
          default: state <= WAIT_B1;
        endcase
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Scoreboard bench: a standard-packet tracker and a wheel/scaled tracker
// share the byte bus; expected packets are queued when their last byte is sent.
module tb_mouse_cursor_tracker;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       valid0, valid1;

  logic [9:0] x_pos0, y_pos0, x_pos1, y_pos1;
  logic [2:0] buttons0, buttons1;
  logic [3:0] wheel0, wheel1;
  logic       pkt_valid0, pkt_valid1, sync_err0, sync_err1;

  typedef struct {
    int x;
    int y;
    int btn;
    int whl;
    int due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int mx[2];
  int my[2];
  int serr_cnt[2];
  int serr_base;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mouse_cursor_tracker #(.TIMEOUT_CYC(TO)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(valid0),
    .x_pos(x_pos0), .y_pos(y_pos0), .buttons(buttons0), .wheel(wheel0),
    .pkt_valid(pkt_valid0), .sync_err(sync_err0)
  );

  mouse_cursor_tracker #(.WHEEL_EN(1), .SPEED_SHIFT(2), .TIMEOUT_CYC(TO)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(valid1),
    .x_pos(x_pos1), .y_pos(y_pos1), .buttons(buttons1), .wheel(wheel1),
    .pkt_valid(pkt_valid1), .sync_err(sync_err1)
  );

  task automatic check_output(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int axis_model(input int pos, input bit sgn, input bit ovf,
                                    input logic [7:0] b, input int shift,
                                    input int res, input bit neg);
    int d;
    int n;
    d = ovf ? 0 : (sgn ? int'(b) - 256 : int'(b));
    d = d * (1 << shift);
    n = neg ? pos - d : pos + d;
    if (n < 0) n = 0;
    if (n > res - 1) n = res - 1;
    return n;
  endfunction

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    valid0  = (sel == 0);
    valid1  = (sel == 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid0 = 1'b0;
      valid1 = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4);
    exp_t e;
    int   shift;
    shift = (sel == 1) ? 2 : 0;
    send_byte(sel, b1);
    send_byte(sel, b2);
    send_byte(sel, b3);
    if (sel == 1) send_byte(sel, b4);
    e.x   = axis_model(mx[sel], b1[4], b1[6], b2, shift, 640, 1'b0);
    e.y   = axis_model(my[sel], b1[5], b1[7], b3, shift, 480, 1'b1);
    e.btn = int'(b1[2:0]);
    e.whl = (sel == 1) ? int'(b4[3:0]) : 0;
    e.due = cyc + 2;
    mx[sel] = e.x;
    my[sel] = e.y;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_x0", int'(x_pos0), 320);
    check_output("rst_y0", int'(y_pos0), 240);
    check_output("rst_btn0", int'(buttons0), 0);
    check_output("rst_whl1", int'(wheel1), 0);
    check_output("rst_pkt0", int'(pkt_valid0), 0);
    check_output("rst_serr0", int'(sync_err0), 0);
    check_output("rst_x1", int'(x_pos1), 320);
    q0.delete();
    q1.delete();
    mx = '{320, 320};
    my = '{240, 240};
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sync_err0) serr_cnt[0]++;
    if (sync_err1) serr_cnt[1]++;
    if (pkt_valid0) begin
      if (q0.size() == 0) check_output("unexpected_pkt0", 1, 0);
      else begin
        e = q0.pop_front();
        check_output("x0", int'(x_pos0), e.x);
        check_output("y0", int'(y_pos0), e.y);
        check_output("btn0", int'(buttons0), e.btn);
        check_output("whl0", int'(wheel0), e.whl);
        check_output("lat0", cyc, e.due);
      end
    end
    if (pkt_valid1) begin
      if (q1.size() == 0) check_output("unexpected_pkt1", 1, 0);
      else begin
        e = q1.pop_front();
        check_output("x1", int'(x_pos1), e.x);
        check_output("y1", int'(y_pos1), e.y);
        check_output("btn1", int'(buttons1), e.btn);
        check_output("whl1", int'(wheel1), e.whl);
        check_output("lat1", cyc, e.due);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    valid0   = 1'b0;
    valid1   = 1'b0;
    serr_cnt = '{0, 0};
    $display("[TB] starting");

    do_reset();
    apply_stimulus(0, 8'h08, 8'h05, 8'h03, 8'h00);
    idle(5);

    // Back-to-back packets: the next first byte lands in the UPDATE cycle.
    do_reset();
    repeat (5) apply_stimulus(0, 8'h18, 8'h9C, 8'h00, 8'h00);
    idle(5);
    check_output("clamp_x0", int'(x_pos0), 0);

    serr_base = serr_cnt[0];
    send_byte(0, 8'h00);
    idle(3);
    check_output("bad_b1_serr", serr_cnt[0] - serr_base, 1);
    apply_stimulus(0, 8'h09, 8'h00, 8'h00, 8'h00);
    idle(5);

    do_reset();
    serr_base = serr_cnt[0];
    send_byte(0, 8'h08);
    send_byte(0, 8'h10);
    idle(TO + 5);
    check_output("timeout_serr", serr_cnt[0] - serr_base, 1);
    apply_stimulus(0, 8'h08, 8'h01, 8'h01, 8'h00);
    idle(5);
    check_output("after_to_x0", int'(x_pos0), 321);
    check_output("after_to_y0", int'(y_pos0), 239);

    // A first byte arriving on the exact timeout cycle starts a new packet.
    serr_base = serr_cnt[0];
    send_byte(0, 8'h08);
    send_byte(0, 8'h10);
    idle(TO);
    apply_stimulus(0, 8'h08, 8'h02, 8'h00, 8'h00);
    idle(5);
    check_output("to_edge_serr", serr_cnt[0] - serr_base, 1);

    serr_base = serr_cnt[0];
    apply_stimulus(0, 8'h48, 8'h7F, 8'h00, 8'h00);
    idle(5);
    check_output("ovf_serr", serr_cnt[0] - serr_base, 0);

    serr_base = serr_cnt[0];
    send_byte(0, 8'h08);
    send_byte(0, 8'h05);
    do_reset();
    apply_stimulus(0, 8'h08, 8'h05, 8'h03, 8'h00);
    idle(5);
    check_output("midrst_serr", serr_cnt[0] - serr_base, 0);

    apply_stimulus(1, 8'h08, 8'h02, 8'h00, 8'h0F);
    idle(5);
    check_output("wheel_x1", int'(x_pos1), 328);
    apply_stimulus(1, 8'h2C, 8'h00, 8'hFF, 8'h03);
    idle(5);
    check_output("wheel_y1", int'(y_pos1), 244);

    check_output("pending_q0", q0.size(), 0);
    check_output("pending_q1", q1.size(), 0);
    check_output("serr1_total", serr_cnt[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_tracker.md
MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

Interface
REQ-001 Parameter H_RES, 640, horizontal cursor range; x_pos is clamped to 0..H_RES-1.
REQ-002 Parameter V_RES, 480, vertical cursor range; y_pos is clamped to 0..V_RES-1.
REQ-003 Parameter POS_W, 10, width of x_pos/y_pos; must satisfy 2^POS_W >= max(H_RES,V_RES).
REQ-004 Parameter WHEEL_EN, 0, 0 = 3-byte standard packets, 1 = 4-byte wheel packets.
REQ-005 Parameter SPEED_SHIFT, 0, left-shift applied to each movement delta (0..3).
REQ-006 Parameter TIMEOUT_CYC, 2_000_000, idle cycles between bytes of one packet before the partial packet is abandoned.
REQ-007 Port clk  in  1  the single system clock; all logic is clocked on its rising edge.
REQ-008 Port rst  in  1  reset; synchronous and active-high.
REQ-009 Port rx_data  in  8  received PS/2 byte; valid only while rx_valid=1.
REQ-010 Port rx_valid  in  1  one-cycle strobe; one byte per strobe.
REQ-011 Port x_pos  out  POS_W  cursor X position.
REQ-012 Port y_pos  out  POS_W  cursor Y position; 0 is the top of the screen.
REQ-013 Port buttons  out  3  {middle,right,left} from the last accepted packet.
REQ-014 Port wheel  out  4  signed wheel delta from the last accepted packet; constant 0 when WHEEL_EN=0.
REQ-015 Port pkt_valid  out  1  one-cycle pulse on the cycle after outputs update.
REQ-016 Port sync_err  out  1  one-cycle pulse when a byte or partial packet is discarded.

Function
REQ-017 FSM states: WAIT_B1, WAIT_B2, WAIT_B3, WAIT_B4, UPDATE; WAIT_B4 is reachable only when WHEEL_EN=1.
REQ-018 In WAIT_B1, a byte with bit3=0 is discarded, sync_err pulses, and the state stays WAIT_B1.
REQ-019 In WAIT_B1, a byte with bit3=1 is stored as byte1 and the state moves to WAIT_B2.
REQ-020 WAIT_B2 stores the X byte on rx_valid; WAIT_B3 stores the Y byte and moves to UPDATE, or to WAIT_B4 when WHEEL_EN=1.
REQ-021 WAIT_B4 stores the wheel byte and moves to UPDATE; wheel takes bits[3:0] of that byte.
REQ-022 Timeout counter: cleared on every rx_valid and held at zero in WAIT_B1; while in WAIT_B2..WAIT_B4 it reaches TIMEOUT_CYC -> go to WAIT_B1 and pulse sync_err.
REQ-023 rx_valid on the same cycle as a timeout: the partial packet is dropped and the byte is evaluated as a WAIT_B1 candidate.
REQ-024 UPDATE lasts exactly one cycle: outputs are registered at the end of it, pkt_valid pulses on the next cycle, and the FSM returns to WAIT_B1.
REQ-025 rx_valid during UPDATE is evaluated as a WAIT_B1 candidate, so no byte is lost.
REQ-026 dx = 9-bit signed {byte1[4], Xbyte}; dy = 9-bit signed {byte1[5], Ybyte}.
REQ-027 Overflow: byte1[6]=1 forces dx=0 and byte1[7]=1 forces dy=0; buttons still update.
REQ-028 Each delta is sign-extended to POS_W+4 bits and then shifted left by SPEED_SHIFT.
REQ-029 x_next = x_pos + dx and y_next = y_pos - dy (PS/2 +Y means up), computed at POS_W+4 bits; each result is clamped to [0, RES-1].
REQ-030 buttons = {byte1[2], byte1[1], byte1[0]} at UPDATE.
REQ-031 Latency from the final byte's rx_valid to the pkt_valid pulse is 2 cycles.

Reset
REQ-032 While rst=1: state=WAIT_B1, timeout counter=0, x_pos=H_RES/2, y_pos=V_RES/2, buttons=0, wheel=0, pkt_valid=0, sync_err=0, stored bytes=0.
REQ-033 Reset asserted mid-packet discards the partial packet without a sync_err pulse.

Structure
REQ-034 Package mouse_pkg holds the FSM state enum, the PS/2 byte1 bit-index constants and the default resolution constants.
REQ-035 One sub-module, mouse_axis_update (signed delta add, shift, clamp, parametrised by RES and POS_W), is instantiated twice, once for X and once for Y.

Verification
REQ-036 Reset, then bytes 08,05,03 -> x_pos=325, y_pos=237, buttons=0, pkt_valid 2 cycles after the third byte.
REQ-037 From reset, 4 packets of 18,9C,00 (dx=-100) -> x_pos=220,120,20,0, clamped at 0; a 5th packet leaves x_pos at 0.
REQ-038 Byte 00 while in WAIT_B1 -> sync_err pulse; the following 09,00,00 is accepted with buttons=001.
REQ-039 Bytes 08,10, then TIMEOUT_CYC idle cycles -> sync_err pulse; the next 08,01,01 yields x_pos=321, y_pos=239.
REQ-040 With WHEEL_EN=1 and SPEED_SHIFT=2: 08,02,00,0F -> x_pos=328, wheel=-1, pkt_valid only after the fourth byte.
REQ-041 Byte1=48 (X overflow) with X byte 7F -> x_pos unchanged, pkt_valid asserted, no sync_err.
